// File: rtl/fetch_stage_unit.sv
// IF stage of the 5-stage MIPS pipeline: PC register, instruction-memory req/ack
// handshake with a one-entry stall buffer, branch redirect/kill, and the IF/ID register.
module fetch_stage_unit #(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(4)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              Hazard_Detected,
  input  logic              Branch_Taken,
  input  logic [ADDR_W-1:0] Branch_Address,
  output logic              Imem_Req,
  output logic [ADDR_W-1:0] Imem_Addr,
  input  logic              Imem_Ack,
  input  logic [INST_W-1:0] Imem_Rdata,
  output logic [ADDR_W-1:0] IF_ID_PC,
  output logic [INST_W-1:0] IF_ID_Inst,
  output logic              IF_ID_Valid
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_BUF  = 2'd2;
  localparam logic [1:0] S_KILL = 2'd3;

  logic [1:0]        state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_next;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] buf_pc;
  logic [INST_W-1:0] buf_inst;

  logic              id_load;
  logic [ADDR_W-1:0] id_pc_d;
  logic [INST_W-1:0] id_inst_d;
  logic              id_valid_d;

  assign pc_next = pc + PC_STEP;

  // In KILL the PC has not moved yet, so the outstanding address is still pc.
  assign Imem_Req  = (state == S_REQ) || (state == S_KILL);
  assign Imem_Addr = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      pc    <= RESET_PC;
    end else begin
      case (state)
        S_IDLE: state <= S_REQ;
        S_REQ: begin
          if (Branch_Taken) begin
            if (Imem_Ack) pc <= Branch_Address;
            else          state <= S_KILL;
          end else if (Imem_Ack) begin
            pc <= pc_next;
            if (Hazard_Detected) state <= S_BUF;
          end
        end
        S_BUF: begin
          if (Branch_Taken) begin
            pc    <= Branch_Address;
            state <= S_REQ;
          end else if (!Hazard_Detected) begin
            state <= S_REQ;
          end
        end
        S_KILL: begin
          if (Imem_Ack) begin
            pc    <= Branch_Taken ? Branch_Address : target;
            state <= S_REQ;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // NOTE: pure data registers are left without reset; the FSM never reads them before writing.
  always_ff @(posedge clk) begin
    if (Branch_Taken && (state == S_REQ || state == S_KILL)) target <= Branch_Address;
    if (state == S_REQ && Imem_Ack && Hazard_Detected && !Branch_Taken) begin
      buf_pc   <= pc_next;
      buf_inst <= Imem_Rdata;
    end
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    id_load    = 1'b0;
    id_pc_d    = '0;
    id_inst_d  = '0;
    id_valid_d = 1'b0;
    if (Branch_Taken) begin
      id_load = 1'b1;
    end else begin
      case (state)
        S_REQ: begin
          if (!Hazard_Detected) begin
            id_load = 1'b1;
            if (Imem_Ack) begin
              id_pc_d    = pc_next;
              id_inst_d  = Imem_Rdata;
              id_valid_d = 1'b1;
            end
          end
        end
        S_BUF: begin
          if (!Hazard_Detected) begin
            id_load    = 1'b1;
            id_pc_d    = buf_pc;
            id_inst_d  = buf_inst;
            id_valid_d = 1'b1;
          end
        end
        S_KILL:  id_load = 1'b1;
        default: id_load = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      IF_ID_PC    <= '0;
      IF_ID_Inst  <= '0;
      IF_ID_Valid <= 1'b0;
    end else if (id_load) begin
      IF_ID_PC    <= id_pc_d;
      IF_ID_Inst  <= id_inst_d;
      IF_ID_Valid <= id_valid_d;
    end
  end

endmodule
